and2_reg: RTL and testbench

- Two-input AND block, vectorised over WIDTH independent lanes.
- Provides:
  - a zero-latency combinational AND output;
  - a registered copy of that output;
  - a per-lane rising-edge pulse;
  - a saturating rising-event counter.
- Sits at the glue-logic level; used wherever a gated qualifier plus a clean registered version and event count are needed.

---
 rtl/and2_reg_if.sv | 25 ++
 rtl/and2_reg.sv | 80 ++++++++
 tb/tb_and2_reg.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/and2_reg_if.sv
// Bus bundle for and2_reg: AND operands, counter clear and all result outputs.
// The master side drives the operands and clr; the slave side (the block) returns the results.
interface and2_reg_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] x1;
  logic             clr;
  logic [WIDTH-1:0] z0;
  logic [WIDTH-1:0] z0_q;
  logic [WIDTH-1:0] rise;
  logic [CNT_W-1:0] rise_cnt;
  logic             cnt_sat;

  modport master (
    output x0, x1, clr,
    input  z0, z0_q, rise, rise_cnt, cnt_sat
  );

  modport slave (
    input  x0, x1, clr,
    output z0, z0_q, rise, rise_cnt, cnt_sat
  );
endinterface

// File: rtl/and2_reg.sv
// Vectorised 2-input AND with a registered copy, per-lane rising-edge pulse and saturating event counter.
// Define AND2_REG_SYNC_EN to put a 2-flop synchroniser on x0/x1 ahead of the registered path.
module and2_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  and2_reg_if.slave   bus
);

  logic [WIDTH-1:0] x0_reg;
  logic [WIDTH-1:0] x1_reg;
  logic [WIDTH-1:0] z0_q_r;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat;

  // Combinational path always uses the raw inputs, even in the synchronised build.
  assign bus.z0 = bus.x0 & bus.x1;

`ifdef AND2_REG_SYNC_EN
  logic [WIDTH-1:0] x0_s1;
  logic [WIDTH-1:0] x0_s2;
  logic [WIDTH-1:0] x1_s1;
  logic [WIDTH-1:0] x1_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_s1 <= '0;
      x0_s2 <= '0;
      x1_s1 <= '0;
      x1_s2 <= '0;
    end else begin
      x0_s1 <= bus.x0;
      x0_s2 <= x0_s1;
      x1_s1 <= bus.x1;
      x1_s2 <= x1_s1;
    end
  end

  assign x0_reg = x0_s2;
  assign x1_reg = x1_s2;
`else
  assign x0_reg = bus.x0;
  assign x1_reg = bus.x1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z0_q_r <= '0;
      prev   <= '0;
      rise_r <= '0;
    end else begin
      z0_q_r <= x0_reg & x1_reg;
      prev   <= z0_q_r;
      rise_r <= z0_q_r & ~prev;
    end
  end

  assign sat = &cnt_r;

  // One count per cycle with any lane pulsing; clr takes priority over a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (bus.clr) begin
      cnt_r <= '0;
    end else if ((|rise_r) && !sat) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.z0_q     = z0_q_r;
  assign bus.rise     = rise_r;
  assign bus.rise_cnt = cnt_r;
  assign bus.cnt_sat  = sat;

endmodule

// File: tb/tb_and2_reg.sv
// Directed self-checking bench for and2_reg: a 1-lane/16-bit instance and a 4-lane/2-bit instance.
module tb_and2_reg;

`ifdef AND2_REG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  and2_reg_if #(.WIDTH(1), .CNT_W(16)) bus_a ();
  and2_reg_if #(.WIDTH(4), .CNT_W(2))  bus_b ();

  and2_reg #(.WIDTH(1), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  and2_reg #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_a();
    bus_a.clr = 1'b1;
    cyc(1);
    bus_a.clr = 1'b0;
  endtask

  task automatic clr_b();
    bus_b.clr = 1'b1;
    cyc(1);
    bus_b.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.x0 = 1'b0; bus_a.x1 = 1'b0; bus_a.clr = 1'b0;
    bus_b.x0 = 4'b0; bus_b.x1 = 4'b0; bus_b.clr = 1'b0;
    #2;
    bus_a.x0 = 1'b1; bus_a.x1 = 1'b1;
    #1;
    checks++;
    if (bus_a.z0 !== 1'b1) begin
      failures++; $display("FAIL reset_z0_follows got=%b exp=1", bus_a.z0);
    end
    cyc(2);
    checks++;
    if (bus_a.z0_q !== 1'b0 || bus_a.rise !== 1'b0 || bus_a.rise_cnt !== 16'd0 || bus_a.cnt_sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_a got z0_q=%b rise=%b cnt=%0d sat=%b exp all 0",
               bus_a.z0_q, bus_a.rise, bus_a.rise_cnt, bus_a.cnt_sat);
    end
    checks++;
    if (bus_b.z0_q !== 4'b0 || bus_b.rise !== 4'b0 || bus_b.rise_cnt !== 2'd0 || bus_b.cnt_sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_b got z0_q=%b rise=%b cnt=%0d sat=%b exp all 0",
               bus_b.z0_q, bus_b.rise, bus_b.rise_cnt, bus_b.cnt_sat);
    end
    bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
    rst_n = 1'b1;
    cyc(LAT + 3);
  endtask

  task automatic test_truth_table();
    logic [1:0] vec  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       expz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus_a.x0 = vec[i][1];
      bus_a.x1 = vec[i][0];
      #1;
      checks++;
      if (bus_a.z0 !== expz[i]) begin
        failures++; $display("FAIL tt_z0 vec=%b got=%b exp=%b", vec[i], bus_a.z0, expz[i]);
      end
      cyc(LAT);
      checks++;
      if (bus_a.z0_q !== expz[i]) begin
        failures++; $display("FAIL tt_z0_q vec=%b got=%b exp=%b", vec[i], bus_a.z0_q, expz[i]);
      end
      cyc(2);
    end
  endtask

  task automatic test_edge_counter();
    int pulses;
    bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
    cyc(LAT + 3);
    clr_a();
    checks++;
    if (bus_a.rise_cnt !== 16'd0) begin
      failures++; $display("FAIL clr_cnt got=%0d exp=0", bus_a.rise_cnt);
    end
    bus_a.x0 = 1'b1; bus_a.x1 = 1'b1;
    pulses = 0;
    for (int i = 0; i < LAT + 7; i++) begin
      cyc(1);
      if (bus_a.rise === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL hold_single_pulse got=%0d exp=1", pulses);
    end
    checks++;
    if (bus_a.rise_cnt !== 16'd1) begin
      failures++; $display("FAIL hold_cnt got=%0d exp=1", bus_a.rise_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
      cyc(LAT + 2);
      bus_a.x0 = 1'b1; bus_a.x1 = 1'b1;
      cyc(LAT + 2);
    end
    checks++;
    if (bus_a.rise_cnt !== 16'd5) begin
      failures++; $display("FAIL toggle_cnt got=%0d exp=5", bus_a.rise_cnt);
    end
  endtask

  task automatic test_clear_priority();
    bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
    cyc(LAT + 2);
    bus_a.x0 = 1'b1; bus_a.x1 = 1'b1;
    cyc(LAT + 1);
    checks++;
    if (bus_a.rise !== 1'b1) begin
      failures++; $display("FAIL clrpri_rise got=%b exp=1", bus_a.rise);
    end
    clr_a();
    checks++;
    if (bus_a.rise_cnt !== 16'd0) begin
      failures++; $display("FAIL clrpri_cnt got=%0d exp=0", bus_a.rise_cnt);
    end
    cyc(2);
    checks++;
    if (bus_a.rise_cnt !== 16'd0) begin
      failures++; $display("FAIL clrpri_cnt_later got=%0d exp=0", bus_a.rise_cnt);
    end
  endtask

  task automatic test_saturation();
    bus_b.x0 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      bus_b.x1 = 4'b0000;
      cyc(LAT + 2);
      bus_b.x1 = 4'b0001;
      cyc(LAT + 2);
      if (i == 1) begin
        checks++;
        if (bus_b.rise_cnt !== 2'd2 || bus_b.cnt_sat !== 1'b0) begin
          failures++; $display("FAIL sat_mid got cnt=%0d sat=%b exp cnt=2 sat=0", bus_b.rise_cnt, bus_b.cnt_sat);
        end
      end
    end
    checks++;
    if (bus_b.rise_cnt !== 2'd3 || bus_b.cnt_sat !== 1'b1) begin
      failures++; $display("FAIL sat_stick got cnt=%0d sat=%b exp cnt=3 sat=1", bus_b.rise_cnt, bus_b.cnt_sat);
    end
    clr_b();
    checks++;
    if (bus_b.rise_cnt !== 2'd0 || bus_b.cnt_sat !== 1'b0) begin
      failures++; $display("FAIL sat_clr got cnt=%0d sat=%b exp cnt=0 sat=0", bus_b.rise_cnt, bus_b.cnt_sat);
    end
  endtask

  task automatic test_multi_lane();
    bus_b.x0 = 4'b0000; bus_b.x1 = 4'b0000;
    cyc(LAT + 3);
    clr_b();
    bus_b.x0 = 4'b1111; bus_b.x1 = 4'b0101;
    #1;
    checks++;
    if (bus_b.z0 !== 4'b0101 || bus_b.z0_q !== 4'b0000) begin
      failures++; $display("FAIL ml_z0 got z0=%b z0_q=%b exp z0=0101 z0_q=0000", bus_b.z0, bus_b.z0_q);
    end
    cyc(LAT);
    checks++;
    if (bus_b.z0_q !== 4'b0101) begin
      failures++; $display("FAIL ml_z0_q got=%b exp=0101", bus_b.z0_q);
    end
    cyc(1);
    checks++;
    if (bus_b.rise !== 4'b0101) begin
      failures++; $display("FAIL ml_rise got=%b exp=0101", bus_b.rise);
    end
    cyc(4);
    checks++;
    if (bus_b.rise_cnt !== 2'd1) begin
      failures++; $display("FAIL ml_cnt got=%0d exp=1", bus_b.rise_cnt);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
    cyc(LAT + 2);
    clr_a();
    for (int i = 0; i < 4; i++) begin
      bus_a.x0 = 1'b0; bus_a.x1 = 1'b0;
      cyc(LAT + 2);
      bus_a.x0 = 1'b1; bus_a.x1 = 1'b1;
      cyc(LAT + 2);
    end
    checks++;
    if (bus_a.rise_cnt !== 16'd4 || bus_a.z0_q !== 1'b1) begin
      failures++; $display("FAIL ar_pre got cnt=%0d z0_q=%b exp cnt=4 z0_q=1", bus_a.rise_cnt, bus_a.z0_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.z0_q !== 1'b0 || bus_a.rise !== 1'b0 || bus_a.rise_cnt !== 16'd0 || bus_a.z0 !== 1'b1) begin
      failures++;
      $display("FAIL ar_assert got z0_q=%b rise=%b cnt=%0d z0=%b exp 0 0 0 1",
               bus_a.z0_q, bus_a.rise, bus_a.rise_cnt, bus_a.z0);
    end
    cyc(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      cyc(1);
      if (bus_a.rise === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus_a.rise_cnt !== 16'd1) begin
      failures++; $display("FAIL ar_release got pulses=%0d cnt=%0d exp pulses=1 cnt=1", pulses, bus_a.rise_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_truth_table();
    test_edge_counter();
    test_clear_priority();
    test_saturation();
    test_multi_lane();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
